// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: grants one master at a time, holds across bursts and locked
// sequences, and tracks the data-phase owner for the return-path muxes.

package ahb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;
endpackage

module ahb_slave_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned SLAVE_X_MASTER_NUM = 3,
    parameter int unsigned ARB_SCHEME         = 1
) (
    input  logic                                  hclk,
    input  logic                                  hreset_n,
    input  logic [SLAVE_X_MASTER_NUM-1:0]         hreq,
    input  htrans_type [SLAVE_X_MASTER_NUM-1:0]   htrans,
    input  logic [SLAVE_X_MASTER_NUM-1:0]         hmastlock,
    input  logic                                  hready,
    output logic [SLAVE_X_MASTER_NUM-1:0]         hgrant,
    output logic [$clog2(SLAVE_X_MASTER_NUM)-1:0] haddr_sel,
    output logic                                  hsel,
    output logic [$clog2(SLAVE_X_MASTER_NUM)-1:0] hdata_sel,
    output logic                                  hdata_valid,
    output logic [SLAVE_X_MASTER_NUM-1:0]         hwait
);

    localparam int unsigned NM = SLAVE_X_MASTER_NUM;
    localparam int unsigned IW = $clog2(SLAVE_X_MASTER_NUM);

    typedef enum logic {
        ArbIdle,
        ArbOwned
    } arb_state_e;

    arb_state_e    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] addr_sel_q, addr_sel_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] data_sel_q;
    logic          data_valid_q;

    htrans_type    owner_trans;
    logic          owner_lock;
    logic          arb_point;
    logic          any_req;
    logic          found;
    logic [IW-1:0] winner;
    logic [IW-1:0] scan_idx;

    assign owner_trans = htrans[addr_sel_q];
    assign owner_lock  = hmastlock[addr_sel_q];
    assign any_req     = |hreq;

    // Owner releases the bus only on IDLE/NONSEQ without lock; SEQ/BUSY/lock hold the grant.
    assign arb_point = hready &&
                       ((state_q == ArbIdle) ||
                        (((owner_trans == IDLE) || (owner_trans == NONSEQ)) && !owner_lock));

    // Winner selection: fixed scans up from 0, round-robin scans up from rr_ptr+1 with wrap.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (ARB_SCHEME == 0) begin
                scan_idx = IW'(k);
            end else begin
                scan_idx = IW'((32'(rr_ptr_q) + k + 32'd1) % NM);
            end
            if (!found && hreq[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_sel_d = addr_sel_q;
        rr_ptr_d   = rr_ptr_q;
        if (arb_point) begin
            if (!any_req) begin
                state_d = ArbIdle;
                grant_d = '0;
            end else begin
                state_d         = ArbOwned;
                grant_d         = '0;
                grant_d[winner] = 1'b1;
                addr_sel_d      = winner;
                if (ARB_SCHEME != 0) begin
                    rr_ptr_d = winner;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q    <= ArbIdle;
            grant_q    <= '0;
            addr_sel_q <= '0;
            rr_ptr_q   <= IW'(NM - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_sel_q <= addr_sel_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Data phase follows the accepted address phase; wait states freeze it.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            data_valid_q <= 1'b0;
            data_sel_q   <= '0;
        end else if (hready) begin
            data_valid_q <= hsel;
            data_sel_q   <= addr_sel_q;
        end
    end

    assign hsel        = (state_q == ArbOwned) && (owner_trans != IDLE);
    assign hgrant      = grant_q;
    assign haddr_sel   = addr_sel_q;
    assign hdata_sel   = data_sel_q;
    assign hdata_valid = data_valid_q;
    assign hwait       = hreq & ~grant_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: fixed-priority and round-robin instances share stimulus and
// are scored against a cycle-level model of the arbitration rules.

module tb_ahb_slave_arbiter;
    import ahb_pkg::*;

    localparam int N = 3;

    typedef htrans_type [N-1:0] tr_vec_t;

    typedef struct {
        int           s;
        logic [N-1:0] grant;
        logic [1:0]   asel;
        logic         hsel;
        logic [1:0]   dsel;
        logic         dv;
        logic [N-1:0] hw;
    } exp_t;

    logic         hclk = 1'b0;
    logic         hreset_n = 1'b0;
    logic [N-1:0] hreq;
    tr_vec_t      htrans;
    logic [N-1:0] hmastlock;
    logic         hready;

    logic [N-1:0] hgrant_w      [2];
    logic [1:0]   haddr_sel_w   [2];
    logic         hsel_w        [2];
    logic [1:0]   hdata_sel_w   [2];
    logic         hdata_valid_w [2];
    logic [N-1:0] hwait_w       [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: index 0 fixed priority, index 1 round-robin.
    int m_owner [2];
    int m_ptr   [2];
    int m_asel  [2];
    int m_dsel  [2];
    bit m_dv    [2];

    exp_t sb[$];
    exp_t mon_e;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(N), .ARB_SCHEME(0)) u_fixed (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .hreq        (hreq),
        .htrans      (htrans),
        .hmastlock   (hmastlock),
        .hready      (hready),
        .hgrant      (hgrant_w[0]),
        .haddr_sel   (haddr_sel_w[0]),
        .hsel        (hsel_w[0]),
        .hdata_sel   (hdata_sel_w[0]),
        .hdata_valid (hdata_valid_w[0]),
        .hwait       (hwait_w[0])
    );

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(N), .ARB_SCHEME(1)) u_rr (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .hreq        (hreq),
        .htrans      (htrans),
        .hmastlock   (hmastlock),
        .hready      (hready),
        .hgrant      (hgrant_w[1]),
        .haddr_sel   (haddr_sel_w[1]),
        .hsel        (hsel_w[1]),
        .hdata_sel   (hdata_sel_w[1]),
        .hdata_valid (hdata_valid_w[1]),
        .hwait       (hwait_w[1])
    );

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_owner[s] = -1;
            m_ptr[s]   = N - 1;
            m_asel[s]  = 0;
            m_dsel[s]  = 0;
            m_dv[s]    = 1'b0;
        end
    endfunction

    function automatic bit model_hsel(int s);
        return (m_owner[s] >= 0) && (htrans[m_asel[s]] != IDLE);
    endfunction

    // Apply one clock edge to the model using the inputs currently on the bus.
    function automatic void model_edge();
        for (int s = 0; s < 2; s++) begin
            bit hs;
            bit hold;
            int w;
            hs   = model_hsel(s);
            hold = (m_owner[s] >= 0) &&
                   ((htrans[m_owner[s]] == SEQ) || (htrans[m_owner[s]] == BUSY) ||
                    (hmastlock[m_owner[s]] == 1'b1));
            if (!hready) continue;
            m_dv[s]   = hs;
            m_dsel[s] = m_asel[s];
            if (hold) continue;
            if (hreq == '0) begin
                m_owner[s] = -1;
            end else begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int cand;
                    cand = (s == 0) ? k : (m_ptr[s] + 1 + k) % N;
                    if (w < 0 && hreq[cand]) w = cand;
                end
                m_owner[s] = w;
                m_asel[s]  = w;
                if (s == 1) m_ptr[s] = w;
            end
        end
    endfunction

    function automatic void push_expected();
        for (int s = 0; s < 2; s++) begin
            exp_t e;
            e.s     = s;
            e.grant = (m_owner[s] < 0) ? '0 : (N'(1) << m_owner[s]);
            e.asel  = 2'(m_asel[s]);
            e.hsel  = model_hsel(s);
            e.dsel  = 2'(m_dsel[s]);
            e.dv    = m_dv[s];
            e.hw    = hreq & ~e.grant;
            sb.push_back(e);
        end
    endfunction

    // Monitor: pops whatever the stimulus queued for this cycle and compares it.
    always @(negedge hclk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if ({hgrant_w[mon_e.s], haddr_sel_w[mon_e.s], hsel_w[mon_e.s],
                 hdata_sel_w[mon_e.s], hdata_valid_w[mon_e.s], hwait_w[mon_e.s]} ===
                {mon_e.grant, mon_e.asel, mon_e.hsel, mon_e.dsel, mon_e.dv, mon_e.hw}) begin
                n_pass++;
            end else begin
                $display("FAIL sb inst%0d t=%0t: got grant=%b asel=%0d hsel=%b dsel=%0d dv=%b wait=%b, expected grant=%b asel=%0d hsel=%b dsel=%0d dv=%b wait=%b",
                         mon_e.s, $time, hgrant_w[mon_e.s], haddr_sel_w[mon_e.s],
                         hsel_w[mon_e.s], hdata_sel_w[mon_e.s], hdata_valid_w[mon_e.s],
                         hwait_w[mon_e.s], mon_e.grant, mon_e.asel, mon_e.hsel,
                         mon_e.dsel, mon_e.dv, mon_e.hw);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic tr_vec_t mk(htrans_type t0, htrans_type t1, htrans_type t2);
        tr_vec_t v;
        v[0] = t0;
        v[1] = t1;
        v[2] = t2;
        return v;
    endfunction

    // Called at posedge+1: drive, queue expectation, advance one edge, update model.
    task automatic step(input logic [N-1:0] rq, input tr_vec_t tr, input logic [N-1:0] lk,
                        input logic rdy);
        hreq      = rq;
        htrans    = tr;
        hmastlock = lk;
        hready    = rdy;
        push_expected();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;

        hreq      = '0;
        htrans    = mk(IDLE, IDLE, IDLE);
        hmastlock = '0;
        hready    = 1'b1;
        model_reset();

        #12;
        for (int s = 0; s < 2; s++) begin
            check("rst_grant", 32'(hgrant_w[s]), 32'd0);
            check("rst_asel", 32'(haddr_sel_w[s]), 32'd0);
            check("rst_dsel", 32'(hdata_sel_w[s]), 32'd0);
            check("rst_dvalid", 32'(hdata_valid_w[s]), 32'd0);
        end
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;

        // All masters request: round-robin rotates, fixed priority sticks to master 0.
        for (int i = 0; i < 4; i++) begin
            step(3'b111, mk(NONSEQ, NONSEQ, NONSEQ), 3'b000, 1'b1);
            check("rr_rotate", 32'(hgrant_w[1]), 32'(rr_exp[i]));
            check("fp_rotate", 32'(hgrant_w[0]), 32'd1);
        end

        // Burst by master 1 with master 0 requesting throughout.
        step(3'b011, mk(NONSEQ, NONSEQ, IDLE), 3'b000, 1'b1);
        step(3'b011, mk(NONSEQ, NONSEQ, IDLE), 3'b000, 1'b1);
        step(3'b011, mk(NONSEQ, SEQ, IDLE), 3'b000, 1'b1);
        step(3'b011, mk(NONSEQ, SEQ, IDLE), 3'b000, 1'b1);
        step(3'b011, mk(NONSEQ, SEQ, IDLE), 3'b000, 1'b1);
        step(3'b001, mk(NONSEQ, IDLE, IDLE), 3'b000, 1'b1);
        step(3'b001, mk(NONSEQ, IDLE, IDLE), 3'b000, 1'b1);

        // Master 2 data phase stretched by wait states while master 0 requests.
        step(3'b100, mk(IDLE, IDLE, NONSEQ), 3'b000, 1'b1);
        step(3'b101, mk(NONSEQ, IDLE, NONSEQ), 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) step(3'b101, mk(NONSEQ, IDLE, IDLE), 3'b000, 1'b0);
        step(3'b101, mk(NONSEQ, IDLE, IDLE), 3'b000, 1'b1);
        step(3'b001, mk(NONSEQ, IDLE, IDLE), 3'b000, 1'b1);

        // Locked singles from master 0 while master 1 requests.
        step(3'b011, mk(NONSEQ, NONSEQ, IDLE), 3'b001, 1'b1);
        step(3'b011, mk(NONSEQ, NONSEQ, IDLE), 3'b001, 1'b1);
        step(3'b011, mk(IDLE, NONSEQ, IDLE), 3'b001, 1'b1);
        step(3'b011, mk(NONSEQ, NONSEQ, IDLE), 3'b000, 1'b1);
        step(3'b010, mk(IDLE, NONSEQ, IDLE), 3'b000, 1'b1);

        // No requests: no parking.
        step(3'b000, mk(IDLE, IDLE, IDLE), 3'b000, 1'b1);
        step(3'b000, mk(IDLE, IDLE, IDLE), 3'b000, 1'b1);
        check("idle_fp", 32'(hgrant_w[0]), 32'd0);
        check("idle_rr", 32'(hgrant_w[1]), 32'd0);

        // Fixed priority starves master 2.
        for (int i = 0; i < 4; i++) begin
            step(3'b110, mk(IDLE, NONSEQ, NONSEQ), 3'b000, 1'b1);
            check("fp_starve", 32'(hgrant_w[0]), 32'd2);
        end

        // Reset asserted asynchronously during master 1's SEQ beat.
        step(3'b010, mk(IDLE, NONSEQ, IDLE), 3'b000, 1'b1);
        step(3'b010, mk(IDLE, NONSEQ, IDLE), 3'b000, 1'b1);
        step(3'b010, mk(IDLE, SEQ, IDLE), 3'b000, 1'b1);
        hreq   = 3'b010;
        htrans = mk(IDLE, SEQ, IDLE);
        #2;
        hreset_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("midrst_grant", 32'(hgrant_w[s]), 32'd0);
            check("midrst_dvalid", 32'(hdata_valid_w[s]), 32'd0);
        end
        model_reset();
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        step(3'b111, mk(NONSEQ, NONSEQ, NONSEQ), 3'b000, 1'b1);
        check("post_rst_rr", 32'(hgrant_w[1]), 32'd1);
        check("post_rst_fp", 32'(hgrant_w[0]), 32'd1);

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            tr_vec_t      tr;
            logic [N-1:0] rq;
            logic [N-1:0] lk;
            for (int i = 0; i < N; i++) begin
                tr[i] = htrans_type'(2'($urandom_range(0, 3)));
                rq[i] = (tr[i] != IDLE) && ($urandom_range(0, 3) != 0);
                lk[i] = ($urandom_range(0, 7) == 0);
            end
            step(rq, tr, lk, $urandom_range(0, 3) != 0);
        end

        step(3'b000, mk(IDLE, IDLE, IDLE), 3'b000, 1'b1);
        @(negedge hclk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
